game_tick_gen: RTL

- Programmable prescaler that produces the single-cycle `count_clk` strobe consumed by the game's event counters (ball step, paddle step, timers).
- Divides the system clock down to a game-tick rate.
- Supports run, pause and single-step.
- Ramps the tick rate up in fixed steps as play continues, so ball speed increases over time.
- Sits directly upstream of the counters; its `tick` output drives their `count_clk` input.

---
 rtl/game_tick_gen_if.sv | 24 ++
 rtl/game_tick_gen.sv | 98 +++++++++
 2 files changed

// File: rtl/game_tick_gen_if.sv
// Control and status bundle for the game tick prescaler.
// The master drives the run/pause/step controls and the slave reports tick and speed.
interface game_tick_gen_if #(
  parameter int unsigned WIDTH = 24
);
  logic             enable;
  logic             pause;
  logic             restart;
  logic             single_step;
  logic             tick;
  logic [WIDTH-1:0] period;
  logic             running;
  logic             at_max_speed;

  modport master (
    output enable, pause, restart, single_step,
    input  tick, period, running, at_max_speed
  );

  modport slave (
    input  enable, pause, restart, single_step,
    output tick, period, running, at_max_speed
  );
endinterface

// File: rtl/game_tick_gen.sv
// Programmable game-tick prescaler with run/pause/single-step control.
// The tick period shrinks by STEP every RAMP_TICKS ticks and stops at MIN_PERIOD.
module game_tick_gen #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned BASE_PERIOD = 500000,
  parameter int unsigned MIN_PERIOD  = 100000,
  parameter int unsigned STEP        = 25000,
  parameter int unsigned RAMP_TICKS  = 64
) (
  input logic             clk,
  input logic             reset,
  game_tick_gen_if.slave  bus
);

  localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [WIDTH-1:0]        BASE_P    = WIDTH'(BASE_PERIOD);
  localparam logic [WIDTH-1:0]        MIN_P     = WIDTH'(MIN_PERIOD);
  localparam logic signed [WIDTH+1:0] STEP_S    = (WIDTH+2)'(STEP);
  localparam logic signed [WIDTH+1:0] MIN_S     = (WIDTH+2)'(MIN_PERIOD);
  localparam logic [RW-1:0]           RAMP_LAST = RW'(RAMP_TICKS - 1);
  localparam logic                    BASE_AT_MIN = (BASE_P == MIN_P);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state;
  logic [WIDTH-1:0] div_cnt;
  logic [WIDTH-1:0] period_q;
  logic [RW-1:0]    ramp_cnt;
  logic             tick_q;
  logic             running_q;
  logic             at_max_q;

  logic             wrap;
  logic [WIDTH-1:0] next_period;

  // Two guard bits keep the subtraction signed so a large STEP can never wrap around.
  function automatic logic [WIDTH-1:0] ramp_period(input logic [WIDTH-1:0] cur);
    logic signed [WIDTH+1:0] diff;
    diff = $signed({2'b00, cur}) - STEP_S;
    return (diff < MIN_S) ? MIN_P : WIDTH'(diff);
  endfunction

  assign wrap        = (div_cnt == period_q - 1'b1);
  assign next_period = ramp_period(period_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      period_q  <= BASE_P;
      at_max_q  <= BASE_AT_MIN;
      div_cnt   <= '0;
      ramp_cnt  <= '0;
    end else if (bus.restart) begin
      tick_q    <= 1'b0;
      period_q  <= BASE_P;
      at_max_q  <= BASE_AT_MIN;
      div_cnt   <= '0;
      ramp_cnt  <= '0;
    end else if (!bus.enable) begin
      state     <= IDLE;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      div_cnt   <= '0;
      ramp_cnt  <= '0;
    end else begin
      tick_q    <= 1'b0;
      state     <= bus.pause ? PAUSE : RUN;
      running_q <= !bus.pause;
      // Counting follows the pause level, so a drop of pause resumes on that very cycle.
      if (state != IDLE) begin
        if (bus.pause) begin
          if (state == PAUSE && bus.single_step) tick_q <= !tick_q;
        end else if (wrap) begin
          div_cnt <= '0;
          tick_q  <= !tick_q;
          if (ramp_cnt == RAMP_LAST) begin
            ramp_cnt <= '0;
            period_q <= next_period;
            at_max_q <= (next_period == MIN_P);
          end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.tick         = tick_q;
  assign bus.period       = period_q;
  assign bus.running      = running_q;
  assign bus.at_max_speed = at_max_q;

endmodule
